// File: rtl/memory_access_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// memory_access_sequencer_pkg
//   Shared types for the memory access sequencer and its bus interface.
//   MemoryMode_t  : mode word presented to the memory controller.
//   MemSeqState_t : sequencer FSM state encoding.
// ----------------------------------------------------------------------------
package memory_access_sequencer_pkg;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_ADDR  = 3'd1,
    LOAD_DATA  = 3'd2,
    ST_PRELOAD = 3'd3,
    ST_COMMIT  = 3'd4,
    FAULT      = 3'd5
  } MemSeqState_t;

  localparam int unsigned MEM_SEQ_COUNTER_WIDTH = 32;

endpackage

// File: rtl/memory_access_sequencer_if.sv
// ----------------------------------------------------------------------------
// memory_access_sequencer_if
//   Groups the decode-side request, the memory controller error flags and
//   the sequencer outputs into one bundle.
//   master : decode stage + memory controller (drives request and error flags)
//   slave  : memory_access_sequencer (drives mode, stall, write-back, status)
//   Signals:
//     memRequest, isStore, funct3          request from decode
//     memoryUnalignedAccess, memoryBadFunct3  controller error flags
//     memoryMode, stallPC, rdWriteEnable, done, memoryFault  sequencer outputs
//     accessCount, stallCycleCount         perf counters (zero unless enabled)
// ----------------------------------------------------------------------------
interface memory_access_sequencer_if
  import memory_access_sequencer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = MEM_SEQ_COUNTER_WIDTH
);

  logic                     memRequest;
  logic                     isStore;
  logic [2:0]               funct3;
  logic                     memoryUnalignedAccess;
  logic                     memoryBadFunct3;
  MemoryMode_t              memoryMode;
  logic                     stallPC;
  logic                     rdWriteEnable;
  logic                     done;
  logic                     memoryFault;
  logic [COUNTER_WIDTH-1:0] accessCount;
  logic [COUNTER_WIDTH-1:0] stallCycleCount;

  modport master (
    output memRequest, isStore, funct3, memoryUnalignedAccess, memoryBadFunct3,
    input  memoryMode, stallPC, rdWriteEnable, done, memoryFault,
           accessCount, stallCycleCount
  );

  modport slave (
    input  memRequest, isStore, funct3, memoryUnalignedAccess, memoryBadFunct3,
    output memoryMode, stallPC, rdWriteEnable, done, memoryFault,
           accessCount, stallCycleCount
  );

endinterface

// File: rtl/memory_access_sequencer.sv
// ----------------------------------------------------------------------------
// memory_access_sequencer
//   Control FSM upstream of the memory controller. Each load/store is run as
//   NOP -> LOAD/STORE_PRELOAD -> LOAD/STORE. The PC is stalled during the
//   first access cycle, loads pulse rd write-back in their second cycle, and
//   any controller error flag seen in the first cycle parks the sequencer in
//   a sticky FAULT state that only reset leaves. Because every store passes
//   through STORE_PRELOAD first, a faulting store never issues STORE.
//
// Ports:
//   clock  in  single clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of memory_access_sequencer_if (see interface header)
//
// Configuration:
//   MEM_SEQ_PERF_COUNT_EN  when defined, accessCount counts done pulses and
//                          stallCycleCount counts cycles with stallPC high
//                          (both wrap). When undefined both are tied to zero
//                          and no counter flops exist.
// ----------------------------------------------------------------------------
module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = MEM_SEQ_COUNTER_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  memory_access_sequencer_if.slave       bus
);

  MemSeqState_t state_q;
  MemSeqState_t state_d;

  MemoryMode_t  mode;
  logic         stall;
  logic         rd_we;
  logic         done_pulse;
  logic         fault;
  logic         mem_error;

  // funct3 is only meaningful to the controller; it is carried on the bus
  // for completeness and intentionally not decoded here.
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3;

  assign mem_error = bus.memoryUnalignedAccess | bus.memoryBadFunct3;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded purely from state, so an asserted reset forces NOP
  // in the same delta without waiting for a clock edge.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    mode       = NOP;
    stall      = 1'b0;
    rd_we      = 1'b0;
    done_pulse = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.memRequest) begin
          state_d = bus.isStore ? ST_PRELOAD : LOAD_ADDR;
        end
      end

      LOAD_ADDR: begin
        mode    = LOAD;
        stall   = 1'b1;
        state_d = mem_error ? FAULT : LOAD_DATA;
      end

      LOAD_DATA: begin
        // Synchronous read backend: data is valid in this cycle.
        mode       = LOAD;
        rd_we      = 1'b1;
        done_pulse = 1'b1;
        state_d    = IDLE;
      end

      ST_PRELOAD: begin
        mode    = STORE_PRELOAD;
        stall   = 1'b1;
        state_d = mem_error ? FAULT : ST_COMMIT;
      end

      ST_COMMIT: begin
        // Already validated in ST_PRELOAD; error flags are not consulted.
        mode       = STORE;
        done_pulse = 1'b1;
        state_d    = IDLE;
      end

      FAULT: begin
        stall   = 1'b1;
        fault   = 1'b1;
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.memoryMode    = mode;
  assign bus.stallPC       = stall;
  assign bus.rdWriteEnable = rd_we;
  assign bus.done          = done_pulse;
  assign bus.memoryFault   = fault;

`ifdef MEM_SEQ_PERF_COUNT_EN
  logic [COUNTER_WIDTH-1:0] access_cnt_q;
  logic [COUNTER_WIDTH-1:0] access_cnt_d;
  logic [COUNTER_WIDTH-1:0] stall_cnt_q;
  logic [COUNTER_WIDTH-1:0] stall_cnt_d;

  // Free-running counters; overflow wraps naturally.
  always_comb begin
    access_cnt_d = done_pulse ? access_cnt_q + COUNTER_WIDTH'(1) : access_cnt_q;
    stall_cnt_d  = stall      ? stall_cnt_q  + COUNTER_WIDTH'(1) : stall_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      access_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      access_cnt_q <= access_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.accessCount     = access_cnt_q;
  assign bus.stallCycleCount = stall_cnt_q;
`else
  assign bus.accessCount     = {COUNTER_WIDTH{1'b0}};
  assign bus.stallCycleCount = {COUNTER_WIDTH{1'b0}};
`endif

endmodule
